// File: rtl/add_sub_seq_if.sv
// Handshake and data bundle for the block-serial adder/subtractor.
// The master side issues operands and start; the slave side returns status and result.
interface add_sub_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, sum, cout, ovf, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, sum, cout, ovf, zero
    );
endinterface

// File: rtl/add_sub_seq.sv
// Block-serial WIDTH-bit adder/subtractor: BLOCK bits per RUN cycle, NBLK cycles per result,
// with carry, signed-overflow and zero flags reported alongside a one-cycle done pulse.
module add_sub_seq #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic         clk,
    input  logic         rst,
    add_sub_seq_if.slave bus
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic [IDXW-1:0]  idx;

    logic [BLOCK-1:0] a_blk;
    logic [BLOCK-1:0] b_blk;
    logic [BLOCK-1:0] s_blk;
    logic             c_blk;
    logic             msb_cin;
    logic             last;
    logic [WIDTH-1:0] sum_next;

    // Block select and slice write are done with a constant-index loop so every
    // part-select stays static regardless of the current block index.
    always_comb begin
        a_blk    = '0;
        b_blk    = '0;
        for (int unsigned i = 0; i < NBLK; i++) begin
            if (idx == IDXW'(i)) begin
                a_blk = opa[i*BLOCK +: BLOCK];
                b_blk = opb[i*BLOCK +: BLOCK];
            end
        end

        {c_blk, s_blk} = {1'b0, a_blk} + {1'b0, b_blk} + {{BLOCK{1'b0}}, carry};
        // Carry into the block MSB recovered from its sum bit and operand bits.
        msb_cin = s_blk[BLOCK-1] ^ a_blk[BLOCK-1] ^ b_blk[BLOCK-1];
        last    = (idx == IDXW'(NBLK - 1));

        sum_next = sum_q;
        for (int unsigned i = 0; i < NBLK; i++) begin
            if (idx == IDXW'(i)) begin
                sum_next[i*BLOCK +: BLOCK] = s_blk;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            idx    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        opa   <= bus.a;
                        opb   <= bus.b ^ {WIDTH{bus.op}};
                        carry <= bus.op;
                        idx   <= '0;
                        sum_q <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum_q <= sum_next;
                    carry <= c_blk;
                    if (last) begin
                        idx    <= '0;
                        cout_q <= c_blk;
                        ovf_q  <= msb_cin ^ c_blk;
                        zero_q <= (sum_next == '0);
                        state  <= DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_add_sub_seq.sv
// Directed bench for add_sub_seq at 32/8, 34/17 and 8/8 configurations.
module tb_add_sub_seq;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    add_sub_seq_if #(.WIDTH(32)) b32 ();
    add_sub_seq_if #(.WIDTH(34)) b34 ();
    add_sub_seq_if #(.WIDTH(8))  b8  ();

    add_sub_seq #(.WIDTH(32), .BLOCK(8))  dut32 (.clk(clk), .rst(rst), .bus(b32));
    add_sub_seq #(.WIDTH(34), .BLOCK(17)) dut34 (.clk(clk), .rst(rst), .bus(b34));
    add_sub_seq #(.WIDTH(8),  .BLOCK(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

    task automatic run32(input logic o, input logic [31:0] x, input logic [31:0] y,
                         output int nbusy, output bit ok);
        @(negedge clk);
        b32.start = 1'b1; b32.op = o; b32.a = x; b32.b = y;
        @(negedge clk);
        b32.start = 1'b0;
        nbusy = 0; ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (b32.done) begin ok = 1'b1; break; end
            if (b32.busy) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic run34(input logic o, input logic [33:0] x, input logic [33:0] y,
                         output int nbusy, output bit ok);
        @(negedge clk);
        b34.start = 1'b1; b34.op = o; b34.a = x; b34.b = y;
        @(negedge clk);
        b34.start = 1'b0;
        nbusy = 0; ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (b34.done) begin ok = 1'b1; break; end
            if (b34.busy) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic run8(input logic o, input logic [7:0] x, input logic [7:0] y,
                        output int nbusy, output bit ok);
        @(negedge clk);
        b8.start = 1'b1; b8.op = o; b8.a = x; b8.b = y;
        @(negedge clk);
        b8.start = 1'b0;
        nbusy = 0; ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (b8.done) begin ok = 1'b1; break; end
            if (b8.busy) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b32.start = 1'b0; b32.op = 1'b0; b32.a = '0; b32.b = '0;
        b34.start = 1'b0; b34.op = 1'b0; b34.a = '0; b34.b = '0;
        b8.start  = 1'b0; b8.op  = 1'b0; b8.a  = '0; b8.b  = '0;
        repeat (2) @(negedge clk);
        tests++;
        if ({b32.busy, b32.done, b32.cout, b32.ovf, b32.zero} !== 5'b0 || b32.sum !== 32'h0) begin
            fails++;
            $display("FAIL reset32: bdcoz=%b sum=%h want 00000 / 0",
                     {b32.busy, b32.done, b32.cout, b32.ovf, b32.zero}, b32.sum);
        end
        tests++;
        if ({b34.busy, b34.done, b34.cout, b34.ovf, b34.zero} !== 5'b0 || b34.sum !== 34'h0) begin
            fails++;
            $display("FAIL reset34: bdcoz=%b sum=%h want 00000 / 0",
                     {b34.busy, b34.done, b34.cout, b34.ovf, b34.zero}, b34.sum);
        end
        tests++;
        if ({b8.busy, b8.done, b8.cout, b8.ovf, b8.zero} !== 5'b0 || b8.sum !== 8'h0) begin
            fails++;
            $display("FAIL reset8: bdcoz=%b sum=%h want 00000 / 0",
                     {b8.busy, b8.done, b8.cout, b8.ovf, b8.zero}, b8.sum);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        int nb; bit ok;
        run32(1'b0, 32'd578, 32'd678, nb, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL add_timeout: no done within 50 cycles"); end
        tests++;
        if (nb !== 4) begin fails++; $display("FAIL add_busy: got %0d cycles want 4", nb); end
        tests++;
        if (b32.sum !== 32'd1256 || {b32.cout, b32.ovf, b32.zero} !== 3'b000) begin
            fails++;
            $display("FAIL add_result: sum=%0d coz=%b want 1256 / 000", b32.sum,
                     {b32.cout, b32.ovf, b32.zero});
        end
        @(negedge clk);
        tests++;
        if (b32.done !== 1'b0 || b32.sum !== 32'd1256) begin
            fails++;
            $display("FAIL add_pulse: done=%b sum=%0d want 0 / 1256", b32.done, b32.sum);
        end
    endtask

    task automatic test_sub();
        int nb; bit ok;
        run32(1'b1, 32'd10, 32'd15, nb, ok);
        tests++;
        if (!ok || b32.sum !== 32'hFFFF_FFFB || {b32.cout, b32.ovf, b32.zero} !== 3'b000) begin
            fails++;
            $display("FAIL sub_borrow: ok=%b sum=%h coz=%b want 1 / fffffffb / 000", ok, b32.sum,
                     {b32.cout, b32.ovf, b32.zero});
        end
        run32(1'b1, 32'd15, 32'd10, nb, ok);
        tests++;
        if (!ok || b32.sum !== 32'd5 || {b32.cout, b32.ovf, b32.zero} !== 3'b100) begin
            fails++;
            $display("FAIL sub_noborrow: ok=%b sum=%h coz=%b want 1 / 5 / 100", ok, b32.sum,
                     {b32.cout, b32.ovf, b32.zero});
        end
    endtask

    task automatic test_overflow();
        int nb; bit ok;
        run32(1'b0, 32'h7FFF_FFFF, 32'd1, nb, ok);
        tests++;
        if (!ok || b32.sum !== 32'h8000_0000 || {b32.cout, b32.ovf, b32.zero} !== 3'b010) begin
            fails++;
            $display("FAIL ovf_pos: ok=%b sum=%h coz=%b want 1 / 80000000 / 010", ok, b32.sum,
                     {b32.cout, b32.ovf, b32.zero});
        end
        run32(1'b0, 32'hFFFF_FFFF, 32'd1, nb, ok);
        tests++;
        if (!ok || b32.sum !== 32'h0 || {b32.cout, b32.ovf, b32.zero} !== 3'b101) begin
            fails++;
            $display("FAIL wrap_zero: ok=%b sum=%h coz=%b want 1 / 0 / 101", ok, b32.sum,
                     {b32.cout, b32.ovf, b32.zero});
        end
    endtask

    task automatic test_ignored_start();
        int nb; bit ok;
        @(negedge clk);
        b32.start = 1'b1; b32.op = 1'b0; b32.a = 32'd100; b32.b = 32'd23;
        @(negedge clk);
        b32.start = 1'b0;
        @(negedge clk);
        b32.start = 1'b1; b32.op = 1'b1; b32.a = 32'h0000_FFFF; b32.b = 32'h0001_0000;
        @(negedge clk);
        b32.start = 1'b0;
        nb = 2; ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (b32.done) begin ok = 1'b1; break; end
            if (b32.busy) nb++;
            @(negedge clk);
        end
        tests++;
        if (!ok || nb !== 4 || b32.sum !== 32'd123) begin
            fails++;
            $display("FAIL ignored_start: ok=%b busy=%0d sum=%0d want 1 / 4 / 123", ok, nb, b32.sum);
        end
        @(negedge clk);
        tests++;
        if (b32.busy !== 1'b0 || b32.done !== 1'b0) begin
            fails++;
            $display("FAIL not_queued: busy=%b done=%b want 0 / 0", b32.busy, b32.done);
        end
    endtask

    task automatic test_back_to_back();
        int nb; int cyc; bit ok;
        run32(1'b0, 32'd1000, 32'd24, nb, ok);
        b32.start = 1'b1; b32.op = 1'b1; b32.a = 32'd7; b32.b = 32'd5;
        @(negedge clk);
        b32.start = 1'b0;
        cyc = 1; ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (b32.done) begin ok = 1'b1; break; end
            cyc++;
            @(negedge clk);
        end
        tests++;
        if (!ok || cyc !== 5) begin
            fails++;
            $display("FAIL b2b_latency: ok=%b gap=%0d want 1 / 5", ok, cyc);
        end
        tests++;
        if (b32.sum !== 32'd2 || {b32.cout, b32.ovf, b32.zero} !== 3'b100) begin
            fails++;
            $display("FAIL b2b_result: sum=%0d coz=%b want 2 / 100", b32.sum,
                     {b32.cout, b32.ovf, b32.zero});
        end
    endtask

    task automatic test_reset_mid();
        int nb; int seen; bit ok;
        run32(1'b0, 32'hFFFF_FFFF, 32'd1, nb, ok);
        @(negedge clk);
        b32.start = 1'b1; b32.op = 1'b0; b32.a = 32'h1234_5678; b32.b = 32'h1111_1111;
        @(negedge clk);
        b32.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({b32.busy, b32.done, b32.cout, b32.ovf, b32.zero} !== 5'b0 || b32.sum !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset: bdcoz=%b sum=%h want 00000 / 0",
                     {b32.busy, b32.done, b32.cout, b32.ovf, b32.zero}, b32.sum);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (b32.done || b32.busy) seen++;
            @(negedge clk);
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL mid_reset_quiet: activity cycles=%0d want 0", seen);
        end
        run32(1'b0, 32'h1234_5678, 32'h1111_1111, nb, ok);
        tests++;
        if (!ok || nb !== 4 || b32.sum !== 32'h2345_6789) begin
            fails++;
            $display("FAIL after_reset: ok=%b busy=%0d sum=%h want 1 / 4 / 23456789", ok, nb, b32.sum);
        end
    endtask

    task automatic test_param();
        int nb; bit ok;
        run34(1'b1, 34'h0, 34'h1, nb, ok);
        tests++;
        if (!ok || nb !== 2 || b34.sum !== 34'h3_FFFF_FFFF || {b34.cout, b34.ovf, b34.zero} !== 3'b000) begin
            fails++;
            $display("FAIL w34_sub: ok=%b busy=%0d sum=%h coz=%b want 1 / 2 / 3ffffffff / 000",
                     ok, nb, b34.sum, {b34.cout, b34.ovf, b34.zero});
        end
        run8(1'b1, 8'h80, 8'h01, nb, ok);
        tests++;
        if (!ok || nb !== 1 || b8.sum !== 8'h7F || {b8.cout, b8.ovf, b8.zero} !== 3'b110) begin
            fails++;
            $display("FAIL w8_ovf: ok=%b busy=%0d sum=%h coz=%b want 1 / 1 / 7f / 110",
                     ok, nb, b8.sum, {b8.cout, b8.ovf, b8.zero});
        end
        run8(1'b0, 8'hC0, 8'h40, nb, ok);
        tests++;
        if (!ok || b8.sum !== 8'h00 || {b8.cout, b8.ovf, b8.zero} !== 3'b101) begin
            fails++;
            $display("FAIL w8_wrap: ok=%b sum=%h coz=%b want 1 / 00 / 101",
                     ok, b8.sum, {b8.cout, b8.ovf, b8.zero});
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_param();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
